chan_frame_packer: RTL and testbench

CHAN_FRAME_PACKER -- requirements
Module: chan_frame_packer

---
 rtl/psec5_readout_pkg.sv | 14 +
 rtl/chan_packer.sv | 34 +++
 rtl/chan_frame_packer.sv | 113 +++++++++++
 tb/tb_chan_frame_packer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/psec5_readout_pkg.sv
// Shared constants and state encoding for the PSEC5 readout frame packer.
package psec5_readout_pkg;

  localparam int NCHAN = 8;
  localparam int NSAMP = 5;
  localparam int SAMPW = 10;
  localparam int CHW   = NSAMP * SAMPW;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

endpackage

// File: rtl/chan_packer.sv
// One channel's staging register: packs NSAMP samples, first sample in the low bits.
module chan_packer #(
  parameter int NSAMP = psec5_readout_pkg::NSAMP,
  parameter int SAMPW = psec5_readout_pkg::SAMPW,
  parameter int CNTW  = $clog2(NSAMP + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr,
  input  logic                   clr,
  input  logic [SAMPW-1:0]       din,
  output logic [NSAMP*SAMPW-1:0] stage,
  output logic [CNTW-1:0]        cnt,
  output logic                   full,
  output logic                   last
);

  assign full = (cnt == CNTW'(NSAMP));
  assign last = (cnt == CNTW'(NSAMP - 1));

  // NOTE: the staging register is reset like any other state because a
  // masked-in channel must commit zeros in slots never written after reset.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      stage <= '0;
      cnt   <= '0;
    end else if (wr) begin
      // NOTE: non-blocking assignments keep the slot index using the old cnt.
      stage[int'(cnt)*SAMPW +: SAMPW] <= din;
      cnt                             <= cnt + CNTW'(1);
    end
  end

endmodule

// File: rtl/chan_frame_packer.sv
// Collects NSAMP samples per masked-in channel, then commits the frame to ch0..ch7.
module chan_frame_packer #(
  parameter int NCHAN = psec5_readout_pkg::NCHAN,
  parameter int NSAMP = psec5_readout_pkg::NSAMP,
  parameter int SAMPW = psec5_readout_pkg::SAMPW
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     samp_valid,
  output logic                     samp_ready,
  input  logic [$clog2(NCHAN)-1:0] samp_chan,
  input  logic [SAMPW-1:0]         samp_data,
  input  logic [NCHAN-1:0]         chan_mask,
  input  logic                     hold,
  input  logic                     err_clr,
  output logic [NSAMP*SAMPW-1:0]   ch0,
  output logic [NSAMP*SAMPW-1:0]   ch1,
  output logic [NSAMP*SAMPW-1:0]   ch2,
  output logic [NSAMP*SAMPW-1:0]   ch3,
  output logic [NSAMP*SAMPW-1:0]   ch4,
  output logic [NSAMP*SAMPW-1:0]   ch5,
  output logic [NSAMP*SAMPW-1:0]   ch6,
  output logic [NSAMP*SAMPW-1:0]   ch7,
  output logic                     frame_done,
  output logic                     overflow
);

  import psec5_readout_pkg::*;

  localparam int FW   = NSAMP * SAMPW;
  localparam int CNTW = $clog2(NSAMP + 1);

  state_t           state;
  logic [NCHAN-1:0] mask_q;
  logic [FW-1:0]    ch_q  [NCHAN];
  logic [FW-1:0]    stage [NCHAN];
  logic [CNTW-1:0]  cnt   [NCHAN];
  logic [NCHAN-1:0] full;
  logic [NCHAN-1:0] last;
  logic [NCHAN-1:0] sel;
  logic [NCHAN-1:0] wr;
  logic             xfer;
  logic             commit;
  logic             drop;
  logic             frame_fill;

  assign samp_ready = (state == FILL);
  assign xfer       = samp_valid && samp_ready;
  assign commit     = (state == FULL) && !hold;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    sel            = '0;
    sel[samp_chan] = 1'b1;
    wr             = xfer ? (sel & mask_q & ~full) : '0;
    drop           = xfer && mask_q[samp_chan] && full[samp_chan];
    // The frame is complete when every masked-in channel is full after this edge.
    frame_fill     = xfer && (|mask_q) && (&(~mask_q | full | (wr & last)));
  end

  for (genvar i = 0; i < NCHAN; i++) begin : g_chan
    chan_packer #(
      .NSAMP (NSAMP),
      .SAMPW (SAMPW),
      .CNTW  (CNTW)
    ) u_chan_packer (
      .clk   (clk),
      .rst   (rst),
      .wr    (wr[i]),
      .clr   (commit),
      .din   (samp_data),
      .stage (stage[i]),
      .cnt   (cnt[i]),
      .full  (full[i]),
      .last  (last[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FILL;
      mask_q     <= chan_mask;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
      for (int i = 0; i < NCHAN; i++) ch_q[i] <= '0;
    end else begin
      frame_done <= 1'b0;
      if (drop)         overflow <= 1'b1;
      else if (err_clr) overflow <= 1'b0;

      case (state)
        FILL: if (frame_fill) state <= FULL;
        FULL: if (!hold) begin
          for (int i = 0; i < NCHAN; i++) ch_q[i] <= mask_q[i] ? stage[i] : '0;
          mask_q     <= chan_mask;
          frame_done <= 1'b1;
          state      <= FILL;
        end
        default: state <= FILL;
      endcase
    end
  end

  assign ch0 = ch_q[0];
  assign ch1 = ch_q[1];
  assign ch2 = ch_q[2];
  assign ch3 = ch_q[3];
  assign ch4 = ch_q[4];
  assign ch5 = ch_q[5];
  assign ch6 = ch_q[6];
  assign ch7 = ch_q[7];

endmodule

// File: tb/tb_chan_frame_packer.sv
// Scoreboard bench for chan_frame_packer: stimulus queues expected frames, monitor checks commits.
module tb_chan_frame_packer;

  localparam int NCH = 8;
  localparam int FW  = 50;

  logic           clk = 1'b0;
  logic           rst;
  logic           samp_valid;
  logic           samp_ready;
  logic [2:0]     samp_chan;
  logic [9:0]     samp_data;
  logic [7:0]     chan_mask;
  logic           hold;
  logic           err_clr;
  logic [FW-1:0]  ch0, ch1, ch2, ch3, ch4, ch5, ch6, ch7;
  logic           frame_done;
  logic           overflow;

  always #5 clk = ~clk;

  chan_frame_packer dut (
    .clk        (clk),
    .rst        (rst),
    .samp_valid (samp_valid),
    .samp_ready (samp_ready),
    .samp_chan  (samp_chan),
    .samp_data  (samp_data),
    .chan_mask  (chan_mask),
    .hold       (hold),
    .err_clr    (err_clr),
    .ch0        (ch0),
    .ch1        (ch1),
    .ch2        (ch2),
    .ch3        (ch3),
    .ch4        (ch4),
    .ch5        (ch5),
    .ch6        (ch6),
    .ch7        (ch7),
    .frame_done (frame_done),
    .overflow   (overflow)
  );

  wire [NCH*FW-1:0] ch_vec = {ch7, ch6, ch5, ch4, ch3, ch2, ch1, ch0};

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  logic [NCH*FW-1:0] exp_q [$];
  logic [NCH*FW-1:0] mon_e;
  logic [FW-1:0]     m_stage [NCH];
  int                m_cnt   [NCH];
  logic [7:0]        m_mask;
  logic [9:0]        c0v     [5] = '{10'h3D3, 10'h2D2, 10'h2D2, 10'h2D2, 10'h2D2};
  logic [FW-1:0]     snap0, snap3;
  int                start_cnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [9:0] dval(input int c, input int k);
    return 10'(c * 37 + k * 101 + 5);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NCH; i++) begin
      m_stage[i] = '0;
      m_cnt[i]   = 0;
    end
  endtask

  // Drives one sample and updates the reference model; a completed frame is queued.
  task automatic send(input int c, input logic [9:0] d);
    int                waited = 0;
    bit                all;
    logic [NCH*FW-1:0] e;
    while (samp_ready !== 1'b1 && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    if (samp_ready !== 1'b1) begin
      check("ready_timeout", samp_ready, 1);
      return;
    end
    samp_valid = 1'b1;
    samp_chan  = 3'(c);
    samp_data  = d;
    @(posedge clk); #1;
    samp_valid = 1'b0;
    if (m_mask[c] && m_cnt[c] < 5) begin
      m_stage[c][m_cnt[c]*10 +: 10] = d;
      m_cnt[c]++;
    end
    if (m_mask != 8'h00) begin
      all = 1'b1;
      for (int i = 0; i < NCH; i++) if (m_mask[i] && m_cnt[i] != 5) all = 1'b0;
      if (all) begin
        for (int i = 0; i < NCH; i++) e[i*FW +: FW] = m_mask[i] ? m_stage[i] : '0;
        exp_q.push_back(e);
        model_clear();
      end
    end
  endtask

  task automatic send_rr(input int from, input int to, input int salt, input bit use_c0);
    for (int n = from; n < to; n++) begin
      if (use_c0 && (n % 8) == 0) send(0, c0v[n / 8]);
      else                        send(n % 8, dval(n % 8, n / 8 + salt));
    end
  endtask

  // Waits a bounded number of cycles for exactly one commit, then relatches the model mask.
  task automatic wait_done(input int budget);
    int start = done_cnt;
    for (int i = 0; i < budget && done_cnt == start; i++) begin
      @(negedge clk); #1;
    end
    check("commit_seen", done_cnt - start, 1);
    m_mask = chan_mask;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    samp_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    m_mask = chan_mask;
    model_clear();
    exp_q.delete();
  endtask

  always @(negedge clk) begin
    if (frame_done === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_frame_done", frame_done, 0);
      end else begin
        mon_e = exp_q.pop_front();
        for (int i = 0; i < NCH; i++)
          check($sformatf("frame_ch%0d", i), ch_vec[i*FW +: FW], mon_e[i*FW +: FW]);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    samp_valid = 1'b0;
    samp_chan  = '0;
    samp_data  = '0;
    chan_mask  = 8'hFF;
    hold       = 1'b0;
    err_clr    = 1'b0;
    @(posedge clk); #1;
    do_reset();
    check("reset_ready", samp_ready, 1);
    check("reset_frame_done", frame_done, 0);
    check("reset_overflow", overflow, 0);
    check("reset_ch_zero", |ch_vec, 0);

    // Full round-robin frame with minimum commit latency.
    send_rr(0, 40, 0, 1'b1);
    @(negedge clk);
    check("latency_no_early_done", frame_done, 0);
    check("full_not_ready", samp_ready, 0);
    wait_done(1);
    check("rr_ch0_packed", ch0, {10'h2D2, 10'h2D2, 10'h2D2, 10'h2D2, 10'h3D3});
    check("rr_overflow", overflow, 0);

    // Mid-frame mask change only applies to the next frame.
    send_rr(0, 20, 1, 1'b0);
    chan_mask = 8'h01;
    send_rr(20, 39, 1, 1'b0);
    check("old_mask_still_filling", samp_ready, 1);
    send_rr(39, 40, 1, 1'b0);
    wait_done(2);
    for (int k = 0; k < 4; k++) send(0, 10'(10'h100 + k));
    check("ch0_only_filling", samp_ready, 1);
    chan_mask = 8'h05;
    send(0, 10'h1F0);
    check("ch0_only_full", samp_ready, 0);
    wait_done(2);

    // Mask 0x05: ch1 samples are discarded silently.
    send(0, 10'h011); send(1, 10'h3AA); send(2, 10'h021);
    send(0, 10'h012); send(1, 10'h3AB); send(2, 10'h022);
    send(0, 10'h013); send(1, 10'h3AC); send(2, 10'h023);
    send(0, 10'h014); send(2, 10'h024); send(0, 10'h015);
    chan_mask = 8'hFF;
    send(2, 10'h025);
    check("masked_out_no_overflow", overflow, 0);
    wait_done(2);
    check("masked_out_ch1_zero", ch1, 0);

    // Frame completes under hold: no commit until hold falls.
    send_rr(0, 39, 2, 1'b0);
    snap0     = ch0;
    snap3     = ch3;
    start_cnt = done_cnt;
    hold      = 1'b1;
    send_rr(39, 40, 2, 1'b0);
    repeat (10) @(negedge clk);
    check("hold_not_ready", samp_ready, 0);
    check("hold_ch0_stable", ch0, snap0);
    check("hold_ch3_stable", ch3, snap3);
    check("hold_no_commit", done_cnt - start_cnt, 0);
    hold = 1'b0;
    wait_done(1);

    // Overflow on a sixth sample, set-wins against err_clr, then clear.
    for (int k = 0; k < 5; k++) send(3, dval(3, k + 9));
    check("ovf_before_sixth", overflow, 0);
    send(3, 10'h3FF);
    check("ovf_after_sixth", overflow, 1);
    err_clr = 1'b1;
    send(3, 10'h155);
    err_clr = 1'b0;
    check("ovf_set_wins", overflow, 1);
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    check("ovf_cleared", overflow, 0);
    for (int c = 0; c < NCH; c++)
      if (c != 3) for (int k = 0; k < 5; k++) send(c, dval(c, k + 9));
    wait_done(2);

    // Reset mid-frame, then a fresh frame commits normally.
    send_rr(0, 20, 4, 1'b0);
    do_reset();
    check("midrst_ch_zero", |ch_vec, 0);
    check("midrst_frame_done", frame_done, 0);
    check("midrst_ready", samp_ready, 1);
    send_rr(0, 40, 7, 1'b0);
    wait_done(2);

    // Mask 0: samples discarded and no commit ever happens.
    chan_mask = 8'h00;
    do_reset();
    start_cnt = done_cnt;
    for (int n = 0; n < 10; n++) send(n % 8, dval(n, 3));
    repeat (5) @(negedge clk);
    check("mask0_ready", samp_ready, 1);
    check("mask0_no_commit", done_cnt - start_cnt, 0);
    check("mask0_no_overflow", overflow, 0);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
